pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register for the rv32i core; it replaces the plain enable-gated stage registers (IF/ID, ID/EX, ...) with a valid/ready handshake stage.
- Carries one DATA_W-bit payload. Typical IF/ID payload: {pc_current, inst, pc_next} = 96 bits.
- Optional 1-entry skid buffer makes in_ready purely registered, which breaks the combinational stall path back to earlier stages.
- Adds synchronous flush (branch/jump squash) with bubble injection and a saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_W, 96: payload width in bits.
- SKID_EN, 1: 1 = 2-entry main+skid storage with registered in_ready; 0 = single register with combinational in_ready.
- BUBBLE, 96'h0: payload value loaded into out_data on reset and on flush.
- CNT_W, 16: stall counter width.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  payload valid to downstream.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  payload to downstream (main register).
- occupancy  output  2  number of held entries: 0, 1 or 2.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All state updates occur on the rising clk edge.
- Reset (rstn=0 at the edge): state EMPTY, out_valid=0, out_data=BUBBLE, skid entry invalid with skid data=BUBBLE, occupancy=0, stall_cnt=0. Reset overrides flush and any handshake, including mid-transfer.
- States (SKID_EN=1): EMPTY (occupancy 0), FULL (main valid, 1), SKID (main and skid valid, 2).
- in_ready with SKID_EN=1: in_ready = (state != SKID). It is a function of registered state only and never depends on out_ready.
- EMPTY:
  - in_fire -> FULL, main <= in_data.
  - Otherwise hold.
- FULL:
  - in_fire & out_fire -> FULL, main <= in_data.
  - in_fire & !out_fire -> SKID, skid <= in_data, main held.
  - !in_fire & out_fire -> EMPTY; out_data keeps its last value (don't-care while out_valid=0).
  - Otherwise hold.
- SKID:
  - in_ready=0.
  - out_fire -> FULL, main <= skid.
  - Otherwise hold.
- Ordering is strict FIFO. No payload is ever duplicated or dropped except by flush.
- SKID_EN=0: only EMPTY and FULL exist. in_ready = !out_valid | out_ready (combinational). Latency is 1 cycle in both modes.
- Throughput: 1 transfer per cycle when out_ready is held high, in both modes.
- flush=1 (rstn=1):
  - Next state EMPTY, out_valid=0, out_data <= BUBBLE, skid invalidated, occupancy=0.
  - A same-cycle in_fire is discarded.
  - A same-cycle out_fire counts as completed, since downstream has consumed it.
  - in_ready is not gated by flush.
- stall_cnt:
  - Increments by 1 in every cycle where out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- out_valid and out_data are direct register outputs. No combinational path from in_* to out_*.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
  - the IF/ID payload field offsets (PC_CUR_LSB=64, INST_LSB=32, PC_NEXT_LSB=0);
  - NOP_INST=32'h0000_0013 for stages that need an architectural NOP bubble.
- One natural sub-module: sat_counter (width CNT_W, inc, clear, saturating), reused by other performance counters.

Test Plan:
- Reset mid-transfer: fill to SKID with 0xA, 0xB, then assert rstn=0 -> next cycle out_valid=0, occupancy=0, out_data=BUBBLE, stall_cnt=0.
- Streaming: out_ready=1, send 0x1..0x8 back-to-back -> out_data = 0x1..0x8 one cycle after each input, in_ready stays 1, stall_cnt=0.
- Backpressure/skid: out_ready=0, send 0x10 then 0x11 -> occupancy reaches 2 and in_ready=0. Release out_ready -> 0x10 then 0x11 emitted in order. stall_cnt equals the number of stalled cycles with out_valid=1.
- Flush in SKID: with 0x20 and 0x21 held, assert flush with in_valid=1 carrying 0x22 -> next cycle occupancy=0, out_data=BUBBLE. 0x22 is never emitted.
- Simultaneous fire in FULL: hold 0x30, present 0x31 with out_ready=1 -> 0x30 consumed, state stays FULL with out_data=0x31.
- Saturation and mode: with CNT_W=3, stall 10 cycles -> stall_cnt=7. Repeat the streaming and backpressure tests with SKID_EN=0 -> same ordering, occupancy never exceeds 1, in_ready follows out_ready when full.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage buffers of the rv32i core:
// stage FSM encoding, IF/ID payload layout and the architectural NOP.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    // IF/ID payload layout: {pc_current, inst, pc_next}
    localparam int unsigned PC_CUR_LSB  = 64;
    localparam int unsigned INST_LSB    = 32;
    localparam int unsigned PC_NEXT_LSB = 0;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic [95:0] ifid_pack(
        input logic [31:0] pc_cur,
        input logic [31:0] inst,
        input logic [31:0] pc_next
    );
        logic [95:0] p;
        p = '0;
        p[PC_CUR_LSB  +: 32] = pc_cur;
        p[INST_LSB    +: 32] = inst;
        p[PC_NEXT_LSB +: 32] = pc_next;
        return p;
    endfunction

    function automatic logic [1:0] state_occupancy(input state_e s);
        case (s)
            ST_FULL: return 2'd1;
            ST_SKID: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter for performance statistics; holds at all-ones,
// synchronous clear via reset or the clear input.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with optional skid entry, flush with
// bubble injection, and a saturating stall-cycle counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned          DATA_W  = 96,
    parameter bit                   SKID_EN = 1'b1,
    parameter logic [DATA_W-1:0]    BUBBLE  = '0,
    parameter int unsigned          CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              valid_q;
    logic              in_fire, out_fire;
    logic              stall_inc;

    // With the skid entry, in_ready depends on registered state only.
    always_comb begin
        if (SKID_EN) begin
            in_ready = (state != ST_SKID);
        end else begin
            in_ready = !valid_q || out_ready;
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_nxt  = BUBBLE;
            skid_nxt  = BUBBLE;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ST_FULL;
                        main_nxt  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire) begin
                        // Only reachable with a skid entry; without it in_ready is low here.
                        if (SKID_EN) begin
                            state_nxt = ST_SKID;
                            skid_nxt  = in_data;
                        end
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_nxt = ST_FULL;
                        main_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state   <= state_nxt;
            valid_q <= (state_nxt != ST_EMPTY);
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state);

    assign stall_inc = valid_q && !out_ready && !flush;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clear (1'b0),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed tests for pipe_stage_buf: skid mode, no-skid mode and a narrow
// stall counter instance, each checked against hand-computed values.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam logic [95:0] A_BUBBLE = 96'(NOP_INST) << INST_LSB;

    logic clk = 1'b0;
    logic rstn, flush;

    logic        a_in_valid, a_out_ready;
    logic [95:0] a_in_data;
    logic        a_in_ready, a_out_valid, c_in_ready, c_out_valid;
    logic [95:0] a_out_data, c_out_data;
    logic [1:0]  a_occ, c_occ;
    logic [15:0] a_stall;
    logic [2:0]  c_stall;

    logic        b_in_valid, b_out_ready, b_in_ready, b_out_valid;
    logic [95:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    int runs = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(96), .SKID_EN(1'b1), .BUBBLE(A_BUBBLE), .CNT_W(16)) u_a (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_buf #(.DATA_W(96), .SKID_EN(1'b0), .CNT_W(16)) u_b (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    pipe_stage_buf #(.DATA_W(96), .SKID_EN(1'b1), .BUBBLE(A_BUBBLE), .CNT_W(3)) u_c (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(a_in_valid), .in_ready(c_in_ready), .in_data(a_in_data),
        .out_valid(c_out_valid), .out_ready(a_out_ready), .out_data(c_out_data),
        .occupancy(c_occ), .stall_cnt(c_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; flush = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        if (a_out_valid !== 1'b0) begin fails++; $display("FAIL rst_a_valid: got %b want 0", a_out_valid); end runs++;
        if (a_out_data !== A_BUBBLE) begin fails++; $display("FAIL rst_a_data: got %h want %h", a_out_data, A_BUBBLE); end runs++;
        if (a_occ !== 2'd0) begin fails++; $display("FAIL rst_a_occ: got %0d want 0", a_occ); end runs++;
        if (a_stall !== 16'd0) begin fails++; $display("FAIL rst_a_stall: got %0d want 0", a_stall); end runs++;
        if (a_in_ready !== 1'b1) begin fails++; $display("FAIL rst_a_in_ready: got %b want 1", a_in_ready); end runs++;
        if (b_out_valid !== 1'b0) begin fails++; $display("FAIL rst_b_valid: got %b want 0", b_out_valid); end runs++;
        if (b_out_data !== 96'h0) begin fails++; $display("FAIL rst_b_data: got %h want 0", b_out_data); end runs++;
        if (b_in_ready !== 1'b1) begin fails++; $display("FAIL rst_b_in_ready: got %b want 1", b_in_ready); end runs++;
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 96'hA;
        step();
        a_in_data = 96'hB;
        step();
        if (a_occ !== 2'd2) begin fails++; $display("FAIL mid_occ_skid: got %0d want 2", a_occ); end runs++;
        if (a_stall !== 16'd1) begin fails++; $display("FAIL mid_stall: got %0d want 1", a_stall); end runs++;
        rstn = 1'b0;
        step();
        rstn = 1'b1; a_in_valid = 1'b0;
        if (a_out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", a_out_valid); end runs++;
        if (a_occ !== 2'd0) begin fails++; $display("FAIL mid_occ: got %0d want 0", a_occ); end runs++;
        if (a_out_data !== A_BUBBLE) begin fails++; $display("FAIL mid_data: got %h want %h", a_out_data, A_BUBBLE); end runs++;
        if (a_stall !== 16'd0) begin fails++; $display("FAIL mid_stall_clr: got %0d want 0", a_stall); end runs++;
    endtask

    task automatic test_streaming();
        do_reset();
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1; a_in_data = 96'(i);
            #1;
            if (a_in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, a_in_ready); end runs++;
            step();
            if (a_out_valid !== 1'b1 || a_out_data !== 96'(i)) begin
                fails++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, 96'(i));
            end runs++;
            if (a_occ !== 2'd1) begin fails++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, a_occ); end runs++;
        end
        a_in_valid = 1'b0;
        step();
        if (a_out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain: got %b want 0", a_out_valid); end runs++;
        if (a_stall !== 16'd0) begin fails++; $display("FAIL stream_stall: got %0d want 0", a_stall); end runs++;
    endtask

    task automatic test_backpressure();
        do_reset();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 96'h10;
        step();
        a_in_data = 96'h11;
        step();
        a_in_valid = 1'b0;
        if (a_occ !== 2'd2) begin fails++; $display("FAIL bp_occ2: got %0d want 2", a_occ); end runs++;
        if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", a_in_ready); end runs++;
        step();
        if (a_out_data !== 96'h10) begin fails++; $display("FAIL bp_head: got %h want 10", a_out_data); end runs++;
        if (a_stall !== 16'd2) begin fails++; $display("FAIL bp_stall_held: got %0d want 2", a_stall); end runs++;
        a_out_ready = 1'b1;
        #1;
        if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_reg: got %b want 0", a_in_ready); end runs++;
        step();
        if (a_out_valid !== 1'b1 || a_out_data !== 96'h11) begin
            fails++; $display("FAIL bp_second: got v=%b d=%h want v=1 d=11", a_out_valid, a_out_data);
        end runs++;
        if (a_occ !== 2'd1) begin fails++; $display("FAIL bp_occ1: got %0d want 1", a_occ); end runs++;
        step();
        if (a_out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b want 0", a_out_valid); end runs++;
        if (a_stall !== 16'd2) begin fails++; $display("FAIL bp_stall: got %0d want 2", a_stall); end runs++;
    endtask

    task automatic test_flush();
        do_reset();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 96'h20;
        step();
        a_in_data = 96'h21;
        step();
        a_in_data = 96'h22; flush = 1'b1;
        step();
        flush = 1'b0; a_in_valid = 1'b0;
        if (a_occ !== 2'd0) begin fails++; $display("FAIL flush_occ: got %0d want 0", a_occ); end runs++;
        if (a_out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", a_out_valid); end runs++;
        if (a_out_data !== A_BUBBLE) begin fails++; $display("FAIL flush_data: got %h want %h", a_out_data, A_BUBBLE); end runs++;
        if (a_stall !== 16'd1) begin fails++; $display("FAIL flush_stall: got %0d want 1", a_stall); end runs++;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (a_out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_emit[%0d]: got v=%b d=%h want v=0", i, a_out_valid, a_out_data); end runs++;
        end
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 96'h23;
        step();
        a_in_data = 96'h24; flush = 1'b1;
        #1;
        if (a_in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b want 1", a_in_ready); end runs++;
        step();
        flush = 1'b0; a_in_valid = 1'b0;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            fails++; $display("FAIL flush_discard: got v=%b occ=%0d want v=0 occ=0", a_out_valid, a_occ);
        end runs++;
        step();
        if (a_out_valid !== 1'b0) begin fails++; $display("FAIL flush_discard_hold: got %b want 0", a_out_valid); end runs++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 96'h30;
        step();
        a_in_data = 96'h31; a_out_ready = 1'b1;
        #1;
        if (a_out_data !== 96'h30) begin fails++; $display("FAIL sim_head: got %h want 30", a_out_data); end runs++;
        step();
        a_in_valid = 1'b0;
        if (a_out_valid !== 1'b1 || a_out_data !== 96'h31 || a_occ !== 2'd1) begin
            fails++; $display("FAIL sim_full: got v=%b d=%h occ=%0d want v=1 d=31 occ=1", a_out_valid, a_out_data, a_occ);
        end runs++;
        step();
        if (a_out_valid !== 1'b0) begin fails++; $display("FAIL sim_empty: got %b want 0", a_out_valid); end runs++;
    endtask

    task automatic test_saturation();
        do_reset();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 96'h40;
        step();
        a_in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) begin
                if (c_stall !== 3'd6) begin fails++; $display("FAIL sat_mid: got %0d want 6", c_stall); end runs++;
            end
        end
        if (c_stall !== 3'd7) begin fails++; $display("FAIL sat_cap: got %0d want 7", c_stall); end runs++;
        if (a_stall !== 16'd10) begin fails++; $display("FAIL sat_wide: got %0d want 10", a_stall); end runs++;
        a_out_ready = 1'b1;
        step();
    endtask

    task automatic test_noskid_streaming();
        do_reset();
        b_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            b_in_valid = 1'b1; b_in_data = 96'(i + 16'h100);
            #1;
            if (b_in_ready !== 1'b1) begin fails++; $display("FAIL ns_stream_in_ready[%0d]: got %b want 1", i, b_in_ready); end runs++;
            step();
            if (b_out_valid !== 1'b1 || b_out_data !== 96'(i + 16'h100) || b_occ !== 2'd1) begin
                fails++; $display("FAIL ns_stream_out[%0d]: got v=%b d=%h occ=%0d want v=1 d=%h occ=1", i, b_out_valid, b_out_data, b_occ, 96'(i + 16'h100));
            end runs++;
        end
        b_in_valid = 1'b0;
        step();
        if (b_out_valid !== 1'b0) begin fails++; $display("FAIL ns_stream_drain: got %b want 0", b_out_valid); end runs++;
    endtask

    task automatic test_noskid_backpressure();
        do_reset();
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 96'h10;
        step();
        b_in_data = 96'h11;
        #1;
        if (b_in_ready !== 1'b0) begin fails++; $display("FAIL ns_bp_in_ready0: got %b want 0", b_in_ready); end runs++;
        step();
        if (b_out_data !== 96'h10 || b_occ !== 2'd1) begin
            fails++; $display("FAIL ns_bp_hold: got d=%h occ=%0d want d=10 occ=1", b_out_data, b_occ);
        end runs++;
        if (b_stall !== 16'd1) begin fails++; $display("FAIL ns_bp_stall: got %0d want 1", b_stall); end runs++;
        b_out_ready = 1'b1;
        #1;
        if (b_in_ready !== 1'b1) begin fails++; $display("FAIL ns_bp_in_ready1: got %b want 1", b_in_ready); end runs++;
        step();
        b_in_valid = 1'b0;
        if (b_out_valid !== 1'b1 || b_out_data !== 96'h11 || b_occ !== 2'd1) begin
            fails++; $display("FAIL ns_bp_second: got v=%b d=%h occ=%0d want v=1 d=11 occ=1", b_out_valid, b_out_data, b_occ);
        end runs++;
        step();
        if (b_out_valid !== 1'b0) begin fails++; $display("FAIL ns_bp_empty: got %b want 0", b_out_valid); end runs++;
        if (b_stall !== 16'd1) begin fails++; $display("FAIL ns_bp_stall_end: got %0d want 1", b_stall); end runs++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_transfer();
        test_streaming();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_saturation();
        test_noskid_streaming();
        test_noskid_backpressure();
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule
